// File: rtl/dma_axi_simple_csr_pkg.sv
// Shared register offsets, bit positions and sequencer state encoding for the
// simple AXI DMA control/status register block.
package dma_axi_simple_csr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } csr_state_e;

    // Word offsets, i.e. PADDR[7:2]
    localparam logic [5:0] OFF_CTRL = 6'h00;
    localparam logic [5:0] OFF_STAT = 6'h01;
    localparam logic [5:0] OFF_SRC  = 6'h02;
    localparam logic [5:0] OFF_DST  = 6'h03;
    localparam logic [5:0] OFF_NUM  = 6'h04;
    localparam logic [5:0] OFF_GO   = 6'h05;
    localparam logic [5:0] OFF_VER  = 6'h07;

    localparam int CTRL_EN_BIT   = 31;
    localparam int CTRL_IE_BIT   = 0;
    localparam int STAT_DONE_BIT = 0;
    localparam int STAT_ERR_BIT  = 2;

    function automatic logic [31:0] pack_stat(input logic       done,
                                              input logic       busy,
                                              input logic       err,
                                              input logic [1:0] state);
        pack_stat = {26'd0, state, 1'b0, err, busy, done};
    endfunction

endpackage

// File: rtl/dma_axi_simple_csr.sv
// APB3 register file and launch/complete sequencer driving the simple AXI DMA core.
// Single clock; PRDATA/PSLVERR are captured in the setup phase so they are stable for the access phase.
module dma_axi_simple_csr
    import dma_axi_simple_csr_pkg::*;
#(
    parameter int          APB_WIDTH_AD = 8,
    parameter logic [31:0] CSR_VERSION  = 32'h2015_0712
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [APB_WIDTH_AD-1:0] PADDR,
    input  logic [31:0]             PWDATA,
    output logic [31:0]             PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    output logic                    DMA_EN,
    output logic                    DMA_GO,
    output logic [31:0]             DMA_SRC,
    output logic [31:0]             DMA_DST,
    output logic [15:0]             DMA_BNUM,
    output logic [7:0]              DMA_CHUNK,
    input  logic                    DMA_BUSY,
    input  logic                    DMA_DONE,
    output logic                    IRQ
);

    csr_state_e  state_q, state_d;
    logic        en_q, en_d;
    logic        ie_q, ie_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic [15:0] bnum_q, bnum_d;
    logic [7:0]  chunk_q, chunk_d;
    logic        go_q, go_d;
    logic        irq_q, irq_d;
    logic [31:0] prdata_q, prdata_d;
    logic        pslverr_q, pslverr_d;

    logic        setup_s;
    logic        access_s;
    logic        wr_ok_s;
    logic        busy_cfg_s;
    logic        err_pred_s;
    logic [5:0]  widx_s;
    logic [31:0] rd_data_s;
    logic        unused_paddr_s;

    assign unused_paddr_s = ^PADDR;

    // APB phase decode, read mux and error prediction for the pending transfer
    always_comb begin
        setup_s    = PSEL & ~PENABLE;
        access_s   = PSEL & PENABLE;
        widx_s     = PADDR[7:2];
        busy_cfg_s = (state_q != ST_IDLE);
        err_pred_s = 1'b0;
        if (PWRITE) begin
            case (widx_s)
                OFF_SRC, OFF_DST, OFF_NUM: err_pred_s = busy_cfg_s;
                OFF_GO:                    err_pred_s = PWDATA[0] & (~en_q | busy_cfg_s);
                default:                   err_pred_s = 1'b0;
            endcase
        end else begin
            err_pred_s = 1'b0;
        end
        case (widx_s)
            OFF_CTRL: rd_data_s = {en_q, 30'd0, ie_q};
            OFF_STAT: rd_data_s = pack_stat(done_q, DMA_BUSY, err_q, state_q);
            OFF_SRC:  rd_data_s = src_q;
            OFF_DST:  rd_data_s = dst_q;
            OFF_NUM:  rd_data_s = {8'd0, chunk_q, bnum_q};
            OFF_VER:  rd_data_s = CSR_VERSION;
            default:  rd_data_s = 32'd0;
        endcase
    end

    // Register writes, W1C status, launch sequencer and output next-state
    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        ie_d    = ie_q;
        done_d  = done_q;
        err_d   = err_q;
        src_d   = src_q;
        dst_d   = dst_q;
        bnum_d  = bnum_q;
        chunk_d = chunk_q;

        // The error decision latched in setup also gates the write, keeping response and effect consistent
        wr_ok_s = access_s & PWRITE & ~pslverr_q;

        if (wr_ok_s) begin
            case (widx_s)
                OFF_CTRL: begin
                    en_d = PWDATA[CTRL_EN_BIT];
                    ie_d = PWDATA[CTRL_IE_BIT];
                end
                OFF_STAT: begin
                    if (PWDATA[STAT_DONE_BIT]) done_d = 1'b0;
                    else                       done_d = done_q;
                    if (PWDATA[STAT_ERR_BIT])  err_d = 1'b0;
                    else                       err_d = err_q;
                end
                OFF_SRC: src_d = PWDATA;
                OFF_DST: dst_d = PWDATA;
                OFF_NUM: begin
                    bnum_d  = PWDATA[15:0];
                    chunk_d = PWDATA[23:16];
                end
                OFF_GO: begin
                    if (PWDATA[0]) begin
                        if (bnum_q == 16'd0) done_d = 1'b1;
                        else                 state_d = ST_ARMED;
                    end else begin
                        state_d = state_q;
                    end
                end
                default: state_d = state_q;
            endcase
        end else if (access_s & PWRITE & pslverr_q & (widx_s == OFF_GO)) begin
            err_d = 1'b1;
        end else begin
            state_d = state_q;
        end

        // Hardware completion is applied after W1C so the set wins
        case (state_q)
            ST_ARMED: begin
                if (DMA_BUSY) state_d = ST_RUN;
                else          state_d = ST_ARMED;
            end
            ST_RUN: begin
                if (~DMA_BUSY & DMA_DONE) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = state_d;
        endcase

        if (~en_d) state_d = ST_IDLE;
        else       state_d = state_d;

        go_d      = (state_d == ST_ARMED);
        irq_d     = done_q & ie_q;
        prdata_d  = (setup_s & ~PWRITE) ? rd_data_s : 32'd0;
        pslverr_d = setup_s & err_pred_s;
    end

    // State register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= ST_IDLE;
            en_q      <= 1'b0;
            ie_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            src_q     <= 32'd0;
            dst_q     <= 32'd0;
            bnum_q    <= 16'd0;
            chunk_q   <= 8'd0;
            go_q      <= 1'b0;
            irq_q     <= 1'b0;
            prdata_q  <= 32'd0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            ie_q      <= ie_d;
            done_q    <= done_d;
            err_q     <= err_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            bnum_q    <= bnum_d;
            chunk_q   <= chunk_d;
            go_q      <= go_d;
            irq_q     <= irq_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
        end
    end

    assign PRDATA    = prdata_q;
    assign PREADY    = 1'b1;
    assign PSLVERR   = pslverr_q;
    assign DMA_EN    = en_q;
    assign DMA_GO    = go_q;
    assign DMA_SRC   = src_q;
    assign DMA_DST   = dst_q;
    assign DMA_BNUM  = bnum_q;
    assign DMA_CHUNK = chunk_q;
    assign IRQ       = irq_q;

endmodule

// File: tb/tb_dma_axi_simple_csr.sv
// Directed, table-driven bench for dma_axi_simple_csr: register map vectors
// followed by hand-written launch/complete/abort/error sequences.
module tb_dma_axi_simple_csr;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [7:0]  PADDR = 8'd0;
    logic [31:0] PWDATA = 32'd0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        DMA_EN;
    logic        DMA_GO;
    logic [31:0] DMA_SRC;
    logic [31:0] DMA_DST;
    logic [15:0] DMA_BNUM;
    logic [7:0]  DMA_CHUNK;
    logic        DMA_BUSY = 1'b0;
    logic        DMA_DONE = 1'b0;
    logic        IRQ;

    int checks = 0;
    int errors = 0;

    dma_axi_simple_csr #(.APB_WIDTH_AD(8), .CSR_VERSION(32'h2015_0712)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .DMA_EN(DMA_EN), .DMA_GO(DMA_GO), .DMA_SRC(DMA_SRC), .DMA_DST(DMA_DST),
        .DMA_BNUM(DMA_BNUM), .DMA_CHUNK(DMA_CHUNK),
        .DMA_BUSY(DMA_BUSY), .DMA_DONE(DMA_DONE), .IRQ(IRQ)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // One zero-wait APB transfer; returns the access-phase PRDATA/PSLVERR
    task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err);
        @(negedge ACLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(negedge ACLK);
        PENABLE = 1'b1;
        rdata = PRDATA;
        err   = PSLVERR;
        @(negedge ACLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic wr_chk(input string name, input logic [7:0] addr, input logic [31:0] wdata,
                          input logic exp_err);
        logic [31:0] rd;
        logic        e;
        apb(1'b1, addr, wdata, rd, e);
        chk(name, {31'd0, e}, {31'd0, exp_err});
    endtask

    task automatic rd_chk(input string name, input logic [7:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        logic        e;
        apb(1'b0, addr, 32'd0, rd, e);
        chk(name, rd, exp);
    endtask

    task automatic cycle();
        @(negedge ACLK);
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;

        vecs[0]  = '{1'b0, 8'h04, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b1, 8'h00, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 32'h0000_0000, 32'h8000_0001, 1'b0};
        vecs[3]  = '{1'b1, 8'h08, 32'h0000_1000, 32'h0000_0000, 1'b0};
        vecs[4]  = '{1'b0, 8'h08, 32'h0000_0000, 32'h0000_1000, 1'b0};
        vecs[5]  = '{1'b1, 8'h0C, 32'h0000_2000, 32'h0000_0000, 1'b0};
        vecs[6]  = '{1'b0, 8'h0C, 32'h0000_0000, 32'h0000_2000, 1'b0};
        vecs[7]  = '{1'b1, 8'h10, 32'hAB10_0040, 32'h0000_0000, 1'b0};
        vecs[8]  = '{1'b0, 8'h10, 32'h0000_0000, 32'h0010_0040, 1'b0};
        vecs[9]  = '{1'b1, 8'h14, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[10] = '{1'b0, 8'h14, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[11] = '{1'b0, 8'h1C, 32'h0000_0000, 32'h2015_0712, 1'b0};
        vecs[12] = '{1'b0, 8'h18, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[13] = '{1'b1, 8'h20, 32'h1234_5678, 32'h0000_0000, 1'b0};
        vecs[14] = '{1'b0, 8'h20, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[15] = '{1'b1, 8'h1C, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[16] = '{1'b0, 8'h1C, 32'h0000_0000, 32'h2015_0712, 1'b0};

        // Reset values while held in reset
        #1;
        chk("rst_prdata", PRDATA, 32'd0);
        chk("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
        chk("rst_go_en_irq", {29'd0, DMA_GO, DMA_EN, IRQ}, 32'd0);
        chk("rst_src", DMA_SRC, 32'd0);
        chk("pready", {31'd0, PREADY}, 32'd1);
        #20;
        ARESETn = 1'b1;

        // Register map vectors
        for (int i = 0; i < 17; i++) begin
            apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, e);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
        end
        chk("dma_en", {31'd0, DMA_EN}, 32'd1);
        chk("dma_src", DMA_SRC, 32'h0000_1000);
        chk("dma_dst", DMA_DST, 32'h0000_2000);
        chk("dma_bnum", {16'd0, DMA_BNUM}, 32'h0000_0040);
        chk("dma_chunk", {24'd0, DMA_CHUNK}, 32'h0000_0010);

        // Normal launch
        wr_chk("go_ok", 8'h14, 32'h1, 1'b0);
        chk("go_rise", {31'd0, DMA_GO}, 32'd1);
        rd_chk("stat_armed", 8'h04, 32'h0000_0010);
        chk("go_held", {31'd0, DMA_GO}, 32'd1);
        DMA_BUSY = 1'b1;
        cycle();
        chk("go_drop_on_busy", {31'd0, DMA_GO}, 32'd0);
        rd_chk("stat_run", 8'h04, 32'h0000_0022);

        // Config writes and GO rejected while running
        wr_chk("src_wr_run_err", 8'h08, 32'h0000_DEAD, 1'b1);
        rd_chk("src_kept", 8'h08, 32'h0000_1000);
        chk("dma_src_kept", DMA_SRC, 32'h0000_1000);
        wr_chk("go_run_err", 8'h14, 32'h1, 1'b1);
        rd_chk("stat_run_err", 8'h04, 32'h0000_0026);
        wr_chk("err_w1c", 8'h04, 32'h4, 1'b0);

        // Completion, DONE and IRQ latency
        DMA_BUSY = 1'b0; DMA_DONE = 1'b1;
        cycle();
        DMA_DONE = 1'b0;
        chk("irq_latency0", {31'd0, IRQ}, 32'd0);
        cycle();
        chk("irq_set", {31'd0, IRQ}, 32'd1);
        rd_chk("stat_done", 8'h04, 32'h0000_0001);
        wr_chk("done_w1c", 8'h04, 32'h1, 1'b0);
        cycle();
        chk("irq_clear", {31'd0, IRQ}, 32'd0);

        // Zero-length transfer
        wr_chk("num_zero", 8'h10, 32'h0010_0000, 1'b0);
        wr_chk("go_zero", 8'h14, 32'h1, 1'b0);
        chk("go_zero_nogo", {31'd0, DMA_GO}, 32'd0);
        rd_chk("stat_zero_done", 8'h04, 32'h0000_0001);
        wr_chk("done_w1c2", 8'h04, 32'h1, 1'b0);

        // GO while disabled
        wr_chk("ctrl_off", 8'h00, 32'h0, 1'b0);
        wr_chk("go_dis_err", 8'h14, 32'h1, 1'b1);
        rd_chk("stat_dis_err", 8'h04, 32'h0000_0004);
        wr_chk("err_w1c2", 8'h04, 32'h4, 1'b0);
        rd_chk("stat_err_clr", 8'h04, 32'h0000_0000);

        // Abort by clearing EN while ARMED, then while RUN
        wr_chk("num_40", 8'h10, 32'h0010_0040, 1'b0);
        wr_chk("ctrl_en", 8'h00, 32'h8000_0000, 1'b0);
        wr_chk("go_abort1", 8'h14, 32'h1, 1'b0);
        chk("go_abort1_up", {31'd0, DMA_GO}, 32'd1);
        wr_chk("ctrl_clr1", 8'h00, 32'h0, 1'b0);
        chk("go_abort1_down", {31'd0, DMA_GO}, 32'd0);
        rd_chk("stat_abort1", 8'h04, 32'h0000_0000);
        wr_chk("ctrl_en2", 8'h00, 32'h8000_0000, 1'b0);
        wr_chk("go_abort2", 8'h14, 32'h1, 1'b0);
        DMA_BUSY = 1'b1;
        cycle();
        wr_chk("ctrl_clr2", 8'h00, 32'h0, 1'b0);
        rd_chk("stat_abort2", 8'h04, 32'h0000_0002);
        DMA_BUSY = 1'b0;
        cycle();

        // Hardware DONE set coinciding with W1C of DONE
        wr_chk("ctrl_en_ie", 8'h00, 32'h8000_0001, 1'b0);
        wr_chk("num_zero2", 8'h10, 32'h0010_0000, 1'b0);
        wr_chk("go_zero2", 8'h14, 32'h1, 1'b0);
        wr_chk("num_40b", 8'h10, 32'h0010_0040, 1'b0);
        wr_chk("go_race", 8'h14, 32'h1, 1'b0);
        DMA_BUSY = 1'b1;
        cycle();
        @(negedge ACLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h04; PWDATA = 32'h1;
        @(negedge ACLK);
        PENABLE = 1'b1; DMA_BUSY = 1'b0; DMA_DONE = 1'b1;
        @(negedge ACLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; DMA_DONE = 1'b0;
        rd_chk("stat_set_wins", 8'h04, 32'h0000_0001);
        chk("irq_before_rst", {31'd0, IRQ}, 32'd1);

        // Asynchronous reset mid-RUN
        wr_chk("go_rst", 8'h14, 32'h1, 1'b0);
        DMA_BUSY = 1'b1;
        cycle();
        #2;
        ARESETn = 1'b0;
        #1;
        chk("arst_outs", {29'd0, DMA_GO, DMA_EN, IRQ}, 32'd0);
        chk("arst_src", DMA_SRC, 32'd0);
        chk("arst_num", {8'd0, DMA_CHUNK, DMA_BNUM}, 32'd0);
        DMA_BUSY = 1'b0;
        #20;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
